b_elevator_ctrl: RTL and testbench
==================================

# b_elevator_ctrl

Two-floor elevator car controller (floor 0 / floor 1), built as a registered Moore state machine. It takes hall-call buttons, in-car buttons and floor-position sensors, and drives the car motor enable and direction. It sits between the button/sensor input conditioning and the motor drive stage. The module is named `b_elevator_ctrl`, and its port order matches the existing `b_elevator` instantiation.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `P0` in 1: hall call at floor 0.
- `P1` in 1: hall call at floor 1.
- `B0` in 1: in-car button for floor 0.
- `B1` in 1: in-car button for floor 1.
- `S0` in 1: sensor, high when the car is level at floor 0.
- `S1` in 1: sensor, high when the car is level at floor 1.
- `b_MD` out 1: motor direction, 1 = up, 0 = down.
- `b_MS` out 1: motor start, 1 = motor running.
- Port order: `clk, rst, P0, P1, B0, B1, S0, S1, b_MD, b_MS`.

## Operation
- State register is 4-bit one-hot `Y[4:1]` with four states:
  - `AT0` = 0001
  - `UP` = 0010
  - `AT1` = 0100
  - `DOWN` = 1000
- Request terms:
  - `req1` = `P1 | B1`, or the latched floor-1 request (see Configuration).
  - `req0` = `P0 | B0`, or the latched floor-0 request.
- Transitions:
  - `AT0`: go to `UP` if `req1`; otherwise stay. `req0` is ignored here.
  - `UP`: go to `AT1` when `S1` = 1; otherwise stay.
  - `AT1`: go to `DOWN` if `req0`; otherwise stay. `req1` is ignored here.
  - `DOWN`: go to `AT0` when `S0` = 1; otherwise stay.
- Outputs are decoded from the state register only, so they are glitch-free:
  - `b_MS` = `UP | DOWN`.
  - `b_MD` = 1 in `UP` and in `AT1`; 0 in `DOWN` and in `AT0`. Direction holds its last travel value while stopped.
- Illegal or non-one-hot state: next state is `AT0`, outputs `b_MS` = 0, `b_MD` = 0.
- Sensors are not required to be high in the `AT` states. A motion state is left only on its target sensor.
- If `S0` and `S1` are both high, only the target sensor of the current motion state matters.

## Timing
- Reset (`rst` = 1 at a clock edge): `Y` = `AT0`, `b_MS` = 0, `b_MD` = 0. Latched requests are cleared. Reset overrides everything, including mid-travel.
- Request to motion: 1 cycle. A request sampled at edge n gives `b_MS` = 1 after edge n.
- Arrival to stop: 1 cycle. A target sensor sampled high at edge n gives `b_MS` = 0 after edge n.
- Departure from floor 1 can happen at the earliest 1 cycle after arrival, if `req0` is already pending.
- Inputs are synchronous to `clk`. Synchronizers and debouncers live upstream.

## Configuration
- Macro: `B_ELEVATOR_REQ_LATCH_EN`.
- Defined:
  - Two flops, `pend0` and `pend1`, capture any single-cycle pulse on `P0|B0` and `P1|B1`.
  - `pend1` clears on entering `AT1`; `pend0` clears on entering `AT0`.
  - A request for the floor the car is parked at is dropped in the same cycle.
- Undefined:
  - No latching; a request must be high at the sampling edge in the `AT` state.

## Structure
- Shared package `b_elevator_pkg` holds:
  - State typedef `elev_state_t` (4-bit one-hot) with the constants `AT0`, `UP`, `AT1`, `DOWN`.
  - Direction constants `DIR_UP` = 1 and `DIR_DOWN` = 0.
- One sub-module, `elev_req_latch`, holds one pending flop with set/clear. It is instantiated twice under the macro.
- Next-state logic, state register and output decode stay in the top module.

## Test plan
- Reset: `rst` = 1 for 3 cycles with `S0` = 1 -> `b_MS` = 0, `b_MD` = 0, `Y` = 0001.
- Up trip: from `AT0`, `B1` = 1 -> next cycle `b_MS` = 1, `b_MD` = 1. Drop `S0`, hold for 15 cycles, then `S1` = 1 -> one cycle later `b_MS` = 0, `b_MD` = 1, `Y` = 0100.
- Down trip: from `AT1`, `B0` = 1 -> `b_MS` = 1, `b_MD` = 0. `S0` = 1 -> stop, `Y` = 0001.
- Same-floor call: in `AT0`, pulse `P0` -> `b_MS` stays 0. In `AT1`, pulse `P1` -> `b_MS` stays 0.
- Latch (macro defined): one-cycle `P1` pulse in `AT0` -> `UP` entered. Without the macro the same pulse, applied off the sampling edge, gives no motion.
- Mid-travel reset: assert `rst` while in `UP` -> next edge `Y` = 0001, `b_MS` = 0, pending requests cleared.

Source files
------------

// File: rtl/b_elevator_pkg.sv
// Shared types and constants for the two-floor elevator car controller.
// Ports: none (package only).
// Holds the one-hot car state encoding and the motor direction constants.
package b_elevator_pkg;

    // One-hot car state; any other pattern is treated as illegal and recovers to AT0.
    typedef enum logic [3:0] {
        AT0  = 4'b0001,
        UP   = 4'b0010,
        AT1  = 4'b0100,
        DOWN = 4'b1000
    } elev_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elev_req_latch.sv
// Single pending-request flop: remembers a floor call until it is served.
// Latency: set visible 1 cycle after the sampling edge; clear wins over set.
// Ports: clk, rst (sync active-high), set_req, clr_req in; pend out (registered).
module elev_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic pend
);

    logic pend_q;
    logic pend_d;

    // Clear has priority so a call for the floor being reached/parked at is dropped.
    always_comb begin
        pend_d = pend_q;
        if (clr_req) begin
            pend_d = 1'b0;
        end else if (set_req) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/b_elevator_ctrl.sv
// Two-floor elevator car controller: registered Moore FSM driving motor start/direction.
// Latency: request or target sensor sampled at edge n -> b_MS changes after edge n.
// Ports: clk, rst (sync active-high), P0/P1 hall calls, B0/B1 car buttons, S0/S1 level
// sensors in; b_MD (1 = up), b_MS (1 = running) out. Optional macro
// B_ELEVATOR_REQ_LATCH_EN adds pending-request flops so single-cycle calls are remembered.
module b_elevator_ctrl
    import b_elevator_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic P0,
    input  logic P1,
    input  logic B0,
    input  logic B1,
    input  logic S0,
    input  logic S1,
    output logic b_MD,
    output logic b_MS
);

    elev_state_t state_q;
    elev_state_t state_d;
    logic        req0;
    logic        req1;

`ifdef B_ELEVATOR_REQ_LATCH_EN
    logic pend0;
    logic pend1;

    // A pending call is served (and dropped) whenever the car will be parked at
    // that floor next cycle: this covers both arrival and a call while parked.
    elev_req_latch u_pend0 (
        .clk     (clk),
        .rst     (rst),
        .set_req (P0 | B0),
        .clr_req (state_d == AT0),
        .pend    (pend0)
    );

    elev_req_latch u_pend1 (
        .clk     (clk),
        .rst     (rst),
        .set_req (P1 | B1),
        .clr_req (state_d == AT1),
        .pend    (pend1)
    );

    assign req0 = P0 | B0 | pend0;
    assign req1 = P1 | B1 | pend1;
`else
    assign req0 = P0 | B0;
    assign req1 = P1 | B1;
`endif

    // Next state. Calls for the floor the car is parked at are ignored; a motion
    // state is left only on its own target sensor.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AT0:     if (req1) state_d = UP;
            UP:      if (S1)   state_d = AT1;
            AT1:     if (req0) state_d = DOWN;
            DOWN:    if (S0)   state_d = AT0;
            default: state_d = AT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AT0;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend on the state register only; direction holds while parked.
    always_comb begin
        b_MS = 1'b0;
        b_MD = DIR_DOWN;
        case (state_q)
            AT0:     begin b_MS = 1'b0; b_MD = DIR_DOWN; end
            UP:      begin b_MS = 1'b1; b_MD = DIR_UP;   end
            AT1:     begin b_MS = 1'b0; b_MD = DIR_UP;   end
            DOWN:    begin b_MS = 1'b1; b_MD = DIR_DOWN; end
            default: begin b_MS = 1'b0; b_MD = DIR_DOWN; end
        endcase
    end

endmodule

// File: tb/tb_b_elevator_ctrl.sv
// Self-checking bench for b_elevator_ctrl: directed trips plus random buttons/sensors,
// checked against a floor/destination model through an expected-output queue.
module tb_b_elevator_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic P0 = 1'b0, P1 = 1'b0, B0 = 1'b0, B1 = 1'b0, S0 = 1'b0, S1 = 1'b0;
    logic b_MD, b_MS;

    always #5 clk = ~clk;

    b_elevator_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .P0   (P0),
        .P1   (P1),
        .B0   (B0),
        .B1   (B1),
        .S0   (S0),
        .S1   (S1),
        .b_MD (b_MD),
        .b_MS (b_MS)
    );

    // Reference model: is the car travelling, and which floor is it at / heading to.
    bit m_moving;
    int m_dest;
    bit m_pend0, m_pend1;

    logic [1:0] exp_q[$];   // {b_MS, b_MD}
    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    task automatic model_step(input bit r, input bit p0, input bit p1, input bit b0,
                              input bit b1, input bit s0, input bit s1);
        bit want0, want1;
        if (r) begin
            m_moving = 1'b0;
            m_dest   = 0;
            m_pend0  = 1'b0;
            m_pend1  = 1'b0;
        end else begin
            want0 = p0 | b0;
            want1 = p1 | b1;
`ifdef B_ELEVATOR_REQ_LATCH_EN
            want0 = want0 | m_pend0;
            want1 = want1 | m_pend1;
`endif
            if (!m_moving) begin
                if (m_dest == 0 && want1) begin
                    m_moving = 1'b1;
                    m_dest   = 1;
                end else if (m_dest == 1 && want0) begin
                    m_moving = 1'b1;
                    m_dest   = 0;
                end
            end else if ((m_dest == 0 && s0) || (m_dest == 1 && s1)) begin
                m_moving = 1'b0;
            end
`ifdef B_ELEVATOR_REQ_LATCH_EN
            m_pend0 = (!m_moving && m_dest == 0) ? 1'b0 : (m_pend0 | p0 | b0);
            m_pend1 = (!m_moving && m_dest == 1) ? 1'b0 : (m_pend1 | p1 | b1);
`endif
        end
        exp_q.push_back({m_moving, (m_dest == 1)});
    endtask

    // One clock cycle of stimulus. With glitch set, P1 pulses high between edges only.
    task automatic cyc(input bit r, input bit p0, input bit p1, input bit b0,
                       input bit b1, input bit s0, input bit s1, input bit glitch);
        @(negedge clk);
        rst = r; P0 = p0; B0 = b0; B1 = b1; S0 = s0; S1 = s1;
        if (glitch) begin
            P1 = 1'b1;
            #2;
            P1 = 1'b0;
        end else begin
            P1 = p1;
        end
        @(posedge clk);
        model_step(r, p0, glitch ? 1'b0 : p1, b0, b1, s0, s1);
    endtask

    // Monitor: outputs are always presented, so one expected entry per clock edge.
    always @(posedge clk) begin
        logic [1:0] e;
        #1;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({b_MS, b_MD} !== e) begin
                n_fail++;
                $display("FAIL cycle %0d ms_md: got MS=%b MD=%b, expected MS=%b MD=%b",
                         cyc_no, b_MS, b_MD, e[1], e[0]);
            end
        end
    end

    initial begin
        // Reset for 3 cycles with the car level at floor 0.
        repeat (3) cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        // Up trip, long travel, arrival.
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        repeat (15) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        // Same-floor call at floor 1, then down trip.
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Both sensors high while going down: only S0 matters.
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        // Same-floor call at floor 0.
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        // Off-edge P1 glitch is never sampled: no motion.
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        // One-cycle P1 pulse, then a B0 pulse during travel (served only if latched).
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Mid-travel reset, with a call pulsed during the travel.
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Randomised buttons and sensors, with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0));
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
